score_neighbor_reader: RTL and testbench

Read-side companion to the score RAM writer in the Needleman-Wunsch datapath. For cell (i,j), it fetches the three neighbour scores the max/compare stage needs from the single-port score RAM, one address per cycle:
- diagonal (i-1,j-1)
- up (i-1,j)
- left (i,j-1)

It presents all three together with a one-cycle valid pulse. It uses the same (N+1)×(N+1) row-major layout: row 0 and column 0 hold initial gap scores, and matrix cell (i,j) lives at (j+1)+(N+1)*(i+1).

---
 rtl/score_neighbor_reader.sv | 148 ++++++++++++++
 tb/tb_score_neighbor_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_neighbor_reader.sv
// Fetches diag/up/left neighbour scores for cell (i,j) from the score RAM, one read per cycle.
// Latency 4 cycles start->valid (1 cycle for out-of-range); start is ignored while busy.
module score_neighbor_reader #(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N+1),
  parameter int addr_lenght = $clog2((N+1)*(N+1))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BitAddr:0]       i,
  input  logic [BitAddr:0]       j,
  input  logic signed [8:0]      ram_dout,
  output logic                   ram_en,
  output logic [addr_lenght-1:0] ram_addr,
  output logic                   busy,
  output logic                   valid,
  output logic                   err,
  output logic signed [8:0]      diag,
  output logic signed [8:0]      up,
  output logic signed [8:0]      left
);

  typedef enum logic [2:0] {IDLE, S_DIAG, S_UP, S_LEFT, S_LAST, S_ERR} state_t;

  localparam logic [BitAddr:0]       NIDX = (BitAddr+1)'(N);
  localparam logic [addr_lenght-1:0] RW   = addr_lenght'(N+1);

  state_t                 state_q, state_d;
  logic [BitAddr:0]       i_q, i_d, j_q, j_d;
  logic                   ram_en_q, ram_en_d;
  logic [addr_lenght-1:0] ram_addr_q, ram_addr_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic signed [8:0]      diag_q, diag_d, up_q, up_d, left_q, left_d;
  logic [addr_lenght-1:0] base_addr;

  // Top-left corner of the 2x2 neighbourhood in the padded (N+1)-wide matrix.
  function automatic logic [addr_lenght-1:0] cell_addr(input logic [BitAddr:0] row,
                                                        input logic [BitAddr:0] col);
    return addr_lenght'(col) + RW * addr_lenght'(row);
  endfunction

  assign base_addr = cell_addr(i_q, j_q);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    ram_en_d   = ram_en_q;
    ram_addr_d = ram_addr_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    diag_d     = diag_q;
    up_d       = up_q;
    left_d     = left_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (i < NIDX && j < NIDX) begin
            i_d        = i;
            j_d        = j;
            err_d      = 1'b0;
            ram_en_d   = 1'b1;
            ram_addr_d = cell_addr(i, j);
            state_d    = S_DIAG;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DIAG: begin
        ram_en_d   = 1'b1;
        ram_addr_d = base_addr + addr_lenght'(1);
        state_d    = S_UP;
      end
      S_UP: begin
        diag_d     = ram_dout;
        ram_en_d   = 1'b1;
        ram_addr_d = base_addr + RW;
        state_d    = S_LEFT;
      end
      S_LEFT: begin
        up_d       = ram_dout;
        ram_en_d   = 1'b0;
        ram_addr_d = '0;
        state_d    = S_LAST;
      end
      S_LAST: begin
        left_d  = ram_dout;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      S_ERR: begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        diag_d  = '0;
        up_d    = '0;
        left_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      diag_q     <= '0;
      up_q       <= '0;
      left_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      diag_q     <= diag_d;
      up_q       <= up_d;
      left_q     <= left_d;
    end
  end

  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign diag     = diag_q;
  assign up       = up_q;
  assign left     = left_q;

endmodule

// File: tb/tb_score_neighbor_reader.sv
// Bench for score_neighbor_reader with N=4, a behavioural registered-read RAM and a neighbour model.
module tb_score_neighbor_reader;
  localparam int N  = 4;
  localparam int BA = $clog2(N+1);
  localparam int AL = $clog2((N+1)*(N+1));
  localparam int R  = N+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [BA:0]          i = '0;
  logic [BA:0]          j = '0;
  logic signed [8:0]    ram_dout = '0;
  logic                 ram_en;
  logic [AL-1:0]        ram_addr;
  logic                 busy, valid, err;
  logic signed [8:0]    diag, up, left;

  score_neighbor_reader #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .i(i), .j(j), .ram_dout(ram_dout),
    .ram_en(ram_en), .ram_addr(ram_addr), .busy(busy), .valid(valid), .err(err),
    .diag(diag), .up(up), .left(left)
  );

  logic signed [8:0] mem [0:R*R-1];
  int addr_log[$];
  int en_count = 0;
  int valid_count = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_en) begin
      addr_log.push_back(int'(ram_addr));
      en_count <= en_count + 1;
    end
    if (valid) valid_count <= valid_count + 1;
  end

  int                obs_lat;
  logic              obs_err, obs_busy_at_valid, obs_valid_next, obs_err_next, obs_busy_ok, obs_err_acc;
  logic signed [8:0] obs_diag, obs_up, obs_left;

  // Reference: neighbours of (ii,jj) read straight from the score matrix.
  task automatic model(input int ii, input int jj, output int lat, output logic e,
                       output logic signed [8:0] d, output logic signed [8:0] u,
                       output logic signed [8:0] l, output int n, output int a[3]);
    if (ii >= N || jj >= N) begin
      lat = 1; e = 1'b1; d = 0; u = 0; l = 0; n = 0; a = '{0, 0, 0};
    end else begin
      a[0] = ii*R + jj; a[1] = ii*R + jj + 1; a[2] = (ii+1)*R + jj;
      lat = 4; e = 1'b0; n = 3; d = mem[a[0]]; u = mem[a[1]]; l = mem[a[2]];
    end
  endtask

  // Called at a negedge with the DUT idle; leaves at a negedge one cycle after valid.
  task automatic run_request(input int ii, input int jj);
    start = 1'b1; i = (BA+1)'(ii); j = (BA+1)'(jj);
    addr_log.delete();
    @(negedge clk);
    start = 1'b0;
    obs_err_acc = err; obs_busy_ok = busy; obs_lat = 0;
    while (!valid && obs_lat < 10) begin
      if (!busy) obs_busy_ok = 1'b0;
      @(negedge clk);
      obs_lat++;
    end
    obs_err = err; obs_diag = diag; obs_up = up; obs_left = left; obs_busy_at_valid = busy;
    @(negedge clk);
    obs_valid_next = valid; obs_err_next = err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({ram_en, ram_addr, busy, valid, err} !== '0) begin errors++; $display("FAIL reset_ctl got %b want 0", {ram_en, ram_addr, busy, valid, err}); end
    checks++; if ({diag, up, left} !== '0) begin errors++; $display("FAIL reset_data got %h want 0", {diag, up, left}); end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if ({ram_en, busy, valid, err, diag, up, left} !== '0) begin errors++; $display("FAIL idle_cycle%0d got %h want 0", c, {ram_en, busy, valid, err, diag, up, left}); end
    end
    checks++; if (en_count !== 0) begin errors++; $display("FAIL idle_en_count got %0d want 0", en_count); end
  endtask

  task automatic test_plan_example();
    for (int a = 0; a < R*R; a++) mem[a] = 9'(a - 10);
    run_request(2, 3);
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL plan_lat got %0d want 4", obs_lat); end
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL plan_naddr got %0d want 3", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 13 || addr_log[1] !== 14 || addr_log[2] !== 18) begin errors++; $display("FAIL plan_addrs got %0d %0d %0d want 13 14 18", addr_log[0], addr_log[1], addr_log[2]); end
    end
    checks++; if (obs_diag !== 9'sd3 || obs_up !== 9'sd4 || obs_left !== 9'sd8) begin errors++; $display("FAIL plan_data got %0d %0d %0d want 3 4 8", obs_diag, obs_up, obs_left); end
    checks++; if (obs_err !== 1'b0 || obs_busy_at_valid !== 1'b0) begin errors++; $display("FAIL plan_flags got err=%b busy=%b want 0 0", obs_err, obs_busy_at_valid); end
    checks++; if (obs_valid_next !== 1'b0) begin errors++; $display("FAIL plan_vwidth got %b want 0", obs_valid_next); end
    checks++; if (obs_busy_ok !== 1'b1) begin errors++; $display("FAIL plan_busy got %b want 1", obs_busy_ok); end
    checks++; if (diag !== 9'sd3 || up !== 9'sd4 || left !== 9'sd8) begin errors++; $display("FAIL plan_hold got %0d %0d %0d want 3 4 8", diag, up, left); end
  endtask

  task automatic test_error_path();
    run_request(4, 1);
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL err_lat got %0d want 1", obs_lat); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", obs_err); end
    checks++; if ({obs_diag, obs_up, obs_left} !== '0) begin errors++; $display("FAIL err_data got %0d %0d %0d want 0 0 0", obs_diag, obs_up, obs_left); end
    checks++; if (addr_log.size() !== 0) begin errors++; $display("FAIL err_ram_en got %0d reads want 0", addr_log.size()); end
    checks++; if (obs_valid_next !== 1'b0 || obs_err_next !== 1'b1) begin errors++; $display("FAIL err_hold got valid=%b err=%b want 0 1", obs_valid_next, obs_err_next); end
  endtask

  task automatic test_corner_zero();
    mem[0] = 9'sd0; mem[1] = -9'sd2; mem[5] = -9'sd2;
    run_request(0, 0);
    checks++; if (obs_err_acc !== 1'b0) begin errors++; $display("FAIL corner_errclr got %b want 0", obs_err_acc); end
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL corner_naddr got %0d want 3", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 0 || addr_log[1] !== 1 || addr_log[2] !== 5) begin errors++; $display("FAIL corner_addrs got %0d %0d %0d want 0 1 5", addr_log[0], addr_log[1], addr_log[2]); end
    end
    checks++; if (obs_diag !== 9'sd0 || obs_up !== -9'sd2 || obs_left !== -9'sd2) begin errors++; $display("FAIL corner_data got %0d %0d %0d want 0 -2 -2", obs_diag, obs_up, obs_left); end
  endtask

  task automatic test_random();
    int lat, n; logic e; logic signed [8:0] d, u, l; int a[3];
    for (int k = 0; k < R*R; k++) mem[k] = 9'($urandom_range(0, 511));
    for (int t = 0; t < 40; t++) begin
      int ii, jj;
      ii = $urandom_range(0, N+1); jj = $urandom_range(0, N+1);
      model(ii, jj, lat, e, d, u, l, n, a);
      run_request(ii, jj);
      checks++; if (obs_lat !== lat || obs_err !== e) begin errors++; $display("FAIL rnd%0d_lat_err (%0d,%0d) got %0d/%b want %0d/%b", t, ii, jj, obs_lat, obs_err, lat, e); end
      checks++; if (obs_diag !== d || obs_up !== u || obs_left !== l) begin errors++; $display("FAIL rnd%0d_data (%0d,%0d) got %0d %0d %0d want %0d %0d %0d", t, ii, jj, obs_diag, obs_up, obs_left, d, u, l); end
      checks++; if (addr_log.size() !== n) begin errors++; $display("FAIL rnd%0d_naddr got %0d want %0d", t, addr_log.size(), n); end
      else for (int k = 0; k < n; k++) begin
        checks++; if (addr_log[k] !== a[k]) begin errors++; $display("FAIL rnd%0d_addr%0d got %0d want %0d", t, k, addr_log[k], a[k]); end
      end
      checks++; if (obs_valid_next !== 1'b0 || obs_err_next !== e || obs_busy_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_pulse got v=%b e=%b b=%b want 0 %b 1", t, obs_valid_next, obs_err_next, obs_busy_ok, e); end
    end
  endtask

  task automatic test_back_to_back();
    int vc0, n, lat; logic e; logic signed [8:0] d, u, l; int a[3];
    vc0 = valid_count;
    start = 1'b1; i = 4'd1; j = 4'd2; addr_log.delete();
    @(negedge clk); start = 1'b0;                         // after E0
    @(negedge clk); start = 1'b1; i = 4'd3; j = 4'd0;     // after E1, sampled at E2
    @(negedge clk); start = 1'b0;                         // after E2
    @(negedge clk); start = 1'b1;                         // after E3, held into E4/E5
    @(negedge clk);                                       // after E4
    model(1, 2, lat, e, d, u, l, n, a);
    checks++; if (valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL b2b_first_flags got v=%b b=%b e=%b want 1 0 0", valid, busy, err); end
    checks++; if (diag !== d || up !== u || left !== l) begin errors++; $display("FAIL b2b_first_data got %0d %0d %0d want %0d %0d %0d", diag, up, left, d, u, l); end
    @(negedge clk); start = 1'b0;                         // after E5
    checks++; if (busy !== 1'b1 || ram_en !== 1'b1 || int'(ram_addr) !== 15 || valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got b=%b en=%b addr=%0d v=%b want 1 1 15 0", busy, ram_en, ram_addr, valid); end
    n = 5;
    while (!valid && n < 15) begin @(negedge clk); n++; end
    checks++; if (n !== 9) begin errors++; $display("FAIL b2b_second_lat got E%0d want E9", n); end
    model(3, 0, lat, e, d, u, l, n, a);
    checks++; if (diag !== d || up !== u || left !== l) begin errors++; $display("FAIL b2b_second_data got %0d %0d %0d want %0d %0d %0d", diag, up, left, d, u, l); end
    @(negedge clk);
    checks++; if (valid_count - vc0 !== 2) begin errors++; $display("FAIL b2b_nvalid got %0d want 2", valid_count - vc0); end
    checks++; if (addr_log.size() !== 6) begin errors++; $display("FAIL b2b_naddr got %0d want 6", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 7 || addr_log[2] !== 12 || addr_log[3] !== 15 || addr_log[5] !== 20) begin errors++; $display("FAIL b2b_addrs got %0d %0d %0d %0d want 7 12 15 20", addr_log[0], addr_log[2], addr_log[3], addr_log[5]); end
    end
  endtask

  task automatic test_async_reset();
    int vc0;
    for (int a = 0; a < R*R; a++) mem[a] = 9'(a - 10);
    vc0 = valid_count;
    start = 1'b1; i = 4'd2; j = 4'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);                                       // after E2: diag captured
    #2 rst = 1'b0;
    #1;
    checks++; if ({ram_en, ram_addr, busy, valid, err} !== '0) begin errors++; $display("FAIL arst_ctl got %b want 0", {ram_en, ram_addr, busy, valid, err}); end
    checks++; if ({diag, up, left} !== '0) begin errors++; $display("FAIL arst_data got %h want 0", {diag, up, left}); end
    @(negedge clk); rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (valid_count !== vc0 || busy !== 1'b0) begin errors++; $display("FAIL arst_novalid got %0d pulses busy=%b want 0 0", valid_count - vc0, busy); end
    run_request(1, 1);
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL arst_naddr got %0d want 3", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 6 || addr_log[1] !== 7 || addr_log[2] !== 11) begin errors++; $display("FAIL arst_addrs got %0d %0d %0d want 6 7 11", addr_log[0], addr_log[1], addr_log[2]); end
    end
    checks++; if (obs_lat !== 4 || obs_diag !== -9'sd4 || obs_up !== -9'sd3 || obs_left !== 9'sd1) begin errors++; $display("FAIL arst_result got lat=%0d %0d %0d %0d want 4 -4 -3 1", obs_lat, obs_diag, obs_up, obs_left); end
  endtask

  initial begin
    test_reset();
    test_plan_example();
    test_error_path();
    test_corner_zero();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
